// File: rtl/bit_reverse_accel_deadlock_pkg.sv
// bit_reverse_accel_deadlock_pkg: shared FSM states, report-beat layout and helpers for the deadlock reporter.
package bit_reverse_accel_deadlock_pkg;
    typedef enum logic [1:0] {MONITOR, REPORT, LATCHED} state_e;
    localparam int SRC_LSB     = 0;
    localparam int SRC_W       = 8;
    localparam int MASK_LSB    = 8;
    localparam int MASK_W      = 8;
    localparam int CNT_LSB     = 16;
    localparam int EVENT_CNT_W = 16;
    localparam int TS_LSB      = 32;
    localparam int TS_W        = 32;
    localparam int REPORT_W    = 64;

    function automatic logic [SRC_W-1:0] first_set(input logic [MASK_W-1:0] m);
        first_set = '0;
        for (int i = MASK_W - 1; i >= 0; i--)
            if (m[i]) first_set = SRC_W'(i);
    endfunction
endpackage

// File: rtl/bit_reverse_accel_deadlock_stall_counter.sv
// bit_reverse_accel_deadlock_stall_counter: counts consecutive blocked cycles of one source, saturating at THRESH,
// and flags the THRESH-th consecutive blocked cycle.
module bit_reverse_accel_deadlock_stall_counter #(
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             block,
    input  logic             enable,
    output logic             trip,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = !(enable && block) ? '0 : (cnt_q == CNT_W'(THRESH)) ? cnt_q : cnt_q + 1'b1;
        trip  = enable && block && (cnt_q == CNT_W'(THRESH - 1));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt = cnt_q;
endmodule

// File: rtl/bit_reverse_accel_deadlock_reporter.sv
// bit_reverse_accel_deadlock_reporter: qualifies monitor block flags, latches the first deadlock and sends one report beat.
// Define DEADLOCK_TIMESTAMP_EN to stamp the report with a free-running 32-bit cycle counter.
module bit_reverse_accel_deadlock_reporter
    import bit_reverse_accel_deadlock_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int THRESH  = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_SRC-1:0]     block_in,
    input  logic                   clear,
    output logic [REPORT_W-1:0]    report_tdata,
    output logic                   report_tvalid,
    input  logic                   report_tready,
    output logic                   deadlock,
    output logic [EVENT_CNT_W-1:0] event_count
);
    state_e                         state_q, state_d;
    logic [REPORT_W-1:0]            data_q, data_d;
    logic [EVENT_CNT_W-1:0]         evt_q, evt_d;
    logic [NUM_SRC-1:0]             trip;
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt;
    logic [TS_W-1:0]                ts;
    logic                           unused_cnt;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        bit_reverse_accel_deadlock_stall_counter #(.THRESH(THRESH), .CNT_W(CNT_W)) u_cnt (
            .clk    (ap_clk),
            .rst_n  (ap_rst_n),
            .block  (block_in[g]),
            .enable (state_q == MONITOR),
            .trip   (trip[g]),
            .cnt    (cnt[g])
        );
    end

    assign unused_cnt = ^cnt;

`ifdef DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) ts_q <= '0;
        else           ts_q <= ts_q + 1'b1;
    assign ts = ts_q;
`else
    assign ts = '0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        evt_d   = evt_q;
        if (state_q == MONITOR && |trip) begin
            evt_d                        = evt_q + EVENT_CNT_W'(evt_q != '1);
            data_d[SRC_LSB +: SRC_W]     = first_set(MASK_W'(trip));
            data_d[MASK_LSB +: MASK_W]   = MASK_W'(trip);
            data_d[CNT_LSB +: EVENT_CNT_W] = evt_d;
            data_d[TS_LSB +: TS_W]       = ts;
            state_d                      = REPORT;
        end
        // clear is deliberately ignored until the beat has been accepted
        if (state_q == REPORT && report_tready) state_d = LATCHED;
        if (state_q == LATCHED && clear)        state_d = MONITOR;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            state_q <= MONITOR;
            data_q  <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            evt_q   <= evt_d;
        end

    assign report_tdata  = data_q;
    assign report_tvalid = state_q == REPORT;
    assign deadlock      = state_q != MONITOR;
    assign event_count   = evt_q;
endmodule

// File: doc/bit_reverse_accel_deadlock_reporter.md
# bit_reverse_accel_deadlock_reporter

Consumer end of the deadlock-monitor `block` signals inside the bit_reverse_accel top. It qualifies each source's block level with a consecutive-cycle threshold and latches the first confirmed deadlock. It then emits one 64-bit report beat on an AXI-Stream master toward the host debug path, and holds the event until software clears it.

## Interface
- NUM_SRC, 2, number of monitor `block` inputs (1..8)
- THRESH, 1024, consecutive blocked cycles needed to confirm a deadlock (≥2)
- CNT_W, 16, stall counter width; THRESH ≤ 2^CNT_W − 1
- ap_clk  in  1  single clock
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- block_in  in  NUM_SRC  level block flags from deadlock monitors, bit i = source i
- clear  in  1  single-cycle pulse from the control register; re-arms the detector
- report_tdata  out  64  report beat
- report_tvalid  out  1  AXI-Stream valid
- report_tready  in  1  AXI-Stream ready
- deadlock  out  1  level: a deadlock is confirmed and not yet cleared
- event_count  out  16  confirmed deadlocks since reset, saturating at 0xFFFF

## Operation
- States: MONITOR, REPORT, LATCHED. Reset state is MONITOR.
- MONITOR: per-source counter cnt[i].
  - When block_in[i]=1, cnt[i] increments, saturating at THRESH.
  - When block_in[i]=0, cnt[i] clears to 0.
  - Source i trips in the cycle where block_in[i]=1 and cnt[i]=THRESH−1, i.e. the THRESH-th consecutive blocked cycle.
- On any trip:
  - trip_mask = all sources tripping that cycle.
  - first_src = lowest tripping index.
  - The timestamp is captured.
  - event_count increments, saturating.
  - Next state is REPORT.
- report_tdata layout:
  - [7:0] first_src
  - [15:8] trip_mask, zero-extended
  - [31:16] event_count after increment
  - [63:32] timestamp, or zero (see Configuration)
- REPORT: tvalid=1 and tdata stable until the cycle with tvalid&&tready; next state is LATCHED.
  - clear is ignored in REPORT; tvalid is never withdrawn.
- LATCHED: tvalid=0. clear → MONITOR.
- All cnt[i] are held at 0 outside MONITOR, so detection restarts from zero after clear.
- A source whose block_in drops for one cycle restarts its count; only strictly consecutive cycles qualify.
- clear in MONITOR has no effect.

## Timing
- Reset values: report_tvalid=0, report_tdata=0, deadlock=0, event_count=0, all cnt=0, state MONITOR, timestamp=0.
- Trip detected at edge N → report_tvalid and deadlock are 1 from edge N+1.
- Minimum latency from the first blocked cycle to tvalid is THRESH cycles.
- tready already high when tvalid rises → handshake in that cycle → LATCHED at the next edge.
- deadlock stays 1 through REPORT and LATCHED. It falls one cycle after clear is sampled in LATCHED.
- Clear and a fresh block in the same cycle: the clear takes effect and counting starts the cycle after MONITOR is entered.
- Async reset mid-REPORT drops tvalid immediately. This is permitted by AXI-Stream reset rules.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- DEADLOCK_TIMESTAMP_EN defined:
  - A 32-bit free-running cycle counter runs from reset and wraps 0xFFFFFFFF→0.
  - Its value in the trip cycle goes into tdata[63:32].
- Not defined:
  - No timestamp counter is instantiated and tdata[63:32]=0.
  - All other behaviour is identical.

## Structure
- Package bit_reverse_accel_deadlock_pkg holds:
  - state enum (MONITOR, REPORT, LATCHED)
  - report field offsets/widths (SRC_LSB=0, MASK_LSB=8, CNT_LSB=16, TS_LSB=32)
  - REPORT_W=64
  - EVENT_CNT_W=16
- One sub-module, bit_reverse_accel_deadlock_stall_counter, instantiated NUM_SRC times.
  - Inputs: block, enable.
  - Outputs: trip, the saturating CNT_W counter.
- The top holds the FSM, the capture registers and the optional timestamp.

## Test plan
Bench uses THRESH=8, NUM_SRC=2, tready=1 unless stated.
- block_in=2'b01 for 7 cycles then 0 → no trip, tvalid stays 0, event_count=0.
- block_in=2'b01 held → tvalid=1 exactly 8 cycles after the first blocked edge; tdata[15:0]=0x0100; event_count=1; deadlock=1.
- block_in=2'b11 rising on the same edge, held → trip_mask=0x03, first_src=0, one beat only.
- tready=0 for 5 cycles after a trip → tdata stable and tvalid=1 throughout; clear pulsed during REPORT is ignored; after tready=1, state is LATCHED and deadlock=1.
- In LATCHED, pulse clear then hold block_in=2'b10 → deadlock=0 the next cycle; second report has first_src=1 and event_count=2.
- With DEADLOCK_TIMESTAMP_EN: trip at cycle 20 after reset release → tdata[63:32]=20. Without the macro → tdata[63:32]=0. Assert ap_rst_n=0 mid-REPORT → tvalid=0 immediately.
